pipe_trace_buffer: RTL and testbench

PIPE_TRACE_BUFFER -- requirements
Module: pipe_trace_buffer

---
 rtl/pipe_trace_buffer.sv | 154 +++++++++++++++
 tb/tb_pipe_trace_buffer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace buffer: circular capture of {pc, inst, class} records around an
// opcode-match or forced trigger, then in-order readout of the retained window.
module pipe_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 32,
    parameter int INST_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              cap_valid,
    input  logic [PC_W-1:0]   cap_pc,
    input  logic [INST_W-1:0] cap_inst,
    input  logic [5:0]        trig_op,
    input  logic [5:0]        trig_mask,
    input  logic [AW-1:0]     post_cnt,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [PC_W-1:0]   rd_pc,
    output logic [INST_W-1:0] rd_inst,
    output logic [2:0]        rd_class,
    output logic              rd_last,
    output logic [1:0]        state,
    output logic [AW:0]       count,
    output logic              triggered,
    output logic              wrapped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    function automatic logic [2:0] classify(input logic [5:0] op);
        logic [2:0] c;
        case (op)
            6'b000010:                                  c = 3'd1;
            6'b010010, 6'b010001, 6'b010000:            c = 3'd2;
            6'b011010, 6'b011001, 6'b011000:            c = 3'd3;
            6'b001101, 6'b001000, 6'b101101, 6'b101101,
            6'b100101:                                  c = 3'd4;
            6'b111010, 6'b100000, 6'b100010:            c = 3'd5;
            6'b110100, 6'b110101:                       c = 3'd6;
            default:                                    c = 3'd0;
        endcase
        return c;
    endfunction

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW:0]     count_q;
    logic [AW-1:0]   post_q;
    logic            triggered_q;
    logic            wrapped_q;

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [2:0]        mem_cls  [DEPTH];

    logic [5:0]    cap_op;
    logic          capturing;
    logic          wr_en;
    logic          trig_hit;
    logic [AW-1:0] rd_idx;

    assign cap_op    = cap_inst[INST_W-1 -: 6];
    assign capturing = (state_q == ARMED) || (state_q == POST);
    // arm and reset both pre-empt capture, so the write strobe must honour them too
    assign wr_en     = !reset && !arm && capturing && cap_valid;
    assign trig_hit  = force_trig || (cap_valid && (((cap_op ^ trig_op) & trig_mask) == 6'd0));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_pc[wr_ptr_q]   <= cap_pc;
            mem_inst[wr_ptr_q] <= cap_inst;
            mem_cls[wr_ptr_q]  <= classify(cap_op);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else if (arm) begin
            state_q     <= ARMED;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            if (capturing && cap_valid) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (count_q == DEPTH_C) begin
                    wrapped_q <= 1'b1;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
            case (state_q)
                IDLE: ;
                ARMED: begin
                    if (trig_hit) begin
                        triggered_q <= 1'b1;
                        post_q      <= post_cnt;
                        state_q     <= (post_cnt == '0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (cap_valid) begin
                        post_q <= post_q - 1'b1;
                        if (post_q == AW'(1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (count_q == '0) begin
                        state_q <= IDLE;
                    end else if (rd_ready) begin
                        count_q <= count_q - 1'b1;
                        if (count_q == (AW+1)'(1)) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // oldest entry; a full buffer (count==DEPTH) truncates to an offset of 0
    assign rd_idx    = wr_ptr_q - count_q[AW-1:0];
    assign rd_valid  = (state_q == DONE) && (count_q != '0);
    assign rd_last   = (state_q == DONE) && (count_q == (AW+1)'(1));
    assign rd_pc     = mem_pc[rd_idx];
    assign rd_inst   = mem_inst[rd_idx];
    assign rd_class  = mem_cls[rd_idx];
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign wrapped   = wrapped_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer (DEPTH=16): capture, trigger, wrap,
// stalled readout, reset/arm aborts and the opcode class table.
module tb_pipe_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset, arm, force_trig, cap_valid, rd_ready;
    logic [31:0] cap_pc, cap_inst;
    logic [5:0]  trig_op, trig_mask;
    logic [AW-1:0] post_cnt;
    logic        rd_valid, rd_last, triggered, wrapped;
    logic [31:0] rd_pc, rd_inst;
    logic [2:0]  rd_class;
    logic [1:0]  state;
    logic [AW:0] count;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] ALU = 32'h0800_0000;  // opcode 000010
    localparam logic [31:0] LDW = 32'h4800_0000;  // opcode 010010

    logic [5:0] ops  [17] = '{6'b000010, 6'b010010, 6'b010001, 6'b010000, 6'b011010,
                              6'b011001, 6'b011000, 6'b001101, 6'b001000, 6'b101101,
                              6'b100101, 6'b111010, 6'b100000, 6'b100010, 6'b110100,
                              6'b110101, 6'b111111};
    logic [2:0] clss [17] = '{3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4,
                              3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6, 3'd6, 3'd0};

    pipe_trace_buffer #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk(clk), .reset(reset), .arm(arm), .force_trig(force_trig),
        .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_inst(cap_inst),
        .trig_op(trig_op), .trig_mask(trig_mask), .post_cnt(post_cnt),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
        .rd_class(rd_class), .rd_last(rd_last), .state(state), .count(count),
        .triggered(triggered), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] inst);
        cap_valid = 1'b1; cap_pc = pc; cap_inst = inst;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; force_trig = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
        cap_pc = '0; cap_inst = '0; trig_op = 6'b010010; trig_mask = 6'b111111; post_cnt = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_triggered", triggered, 0);
        chk("rst_wrapped", wrapped, 0);

        // 5 ALU, LDW trigger, 2 post records
        do_arm();
        chk("arm_state", state, 1);
        post_cnt = 4'd2;
        for (int i = 0; i < 5; i++) cap(32'(4*i), ALU);
        chk("pre_trig_state", state, 1);
        cap(32'h14, LDW);
        chk("trig_state", state, 2);
        chk("trig_flag", triggered, 1);
        cap(32'h18, ALU);
        chk("post1_state", state, 2);
        cap(32'h1C, ALU);
        chk("done_state", state, 3);
        chk("done_count", count, 8);
        chk("first_class", rd_class, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("rd1_valid", rd_valid, 1);
            chk("rd1_pc", rd_pc, 64'(4*i));
            chk("rd1_class", rd_class, (i == 5) ? 2 : 1);
            chk("rd1_last", rd_last, (i == 7) ? 1 : 0);
            tick();
        end
        rd_ready = 1'b0;
        chk("rd1_idle", state, 0);
        chk("rd1_valid_off", rd_valid, 0);

        // wrap: 19 ALU + LDW trigger as 20th record, post_cnt 0
        do_arm();
        post_cnt = 4'd0;
        for (int i = 0; i < 19; i++) cap(32'h100 + 32'(4*i), ALU);
        chk("wrap_flag", wrapped, 1);
        chk("wrap_armed", state, 1);
        cap(32'h14C, LDW);
        chk("wrap_done", state, 3);
        chk("wrap_count", count, 16);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("rd2_pc", rd_pc, 64'(32'h110 + 32'(4*i)));
            tick();
        end
        rd_ready = 1'b0;
        chk("rd2_idle", state, 0);

        // forced trigger without a record, then stalled readout, then arm mid-readout
        do_arm();
        cap(32'h300, ALU);
        cap(32'h304, ALU);
        force_trig = 1'b1; post_cnt = 4'd3;
        tick();
        force_trig = 1'b0;
        chk("force_state", state, 2);
        chk("force_count", count, 2);
        chk("force_trig_flag", triggered, 1);
        cap(32'h308, ALU);
        cap(32'h30C, ALU);
        cap(32'h310, ALU);
        chk("force_done", state, 3);
        chk("force_done_count", count, 5);
        rd_ready = 1'b1;
        chk("stall_pc0", rd_pc, 32'h300);
        tick();
        rd_ready = 1'b0;
        chk("stall_cnt1", count, 4);
        chk("stall_pc1a", rd_pc, 32'h304);
        tick();
        chk("stall_pc1b", rd_pc, 32'h304);
        chk("stall_cnt2", count, 4);
        tick();
        chk("stall_pc1c", rd_pc, 32'h304);
        chk("stall_valid", rd_valid, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("stall_cnt3", count, 3);
        chk("stall_pc2", rd_pc, 32'h308);
        do_arm();
        chk("rearm_state", state, 1);
        chk("rearm_count", count, 0);
        chk("rearm_trig", triggered, 0);

        // arm beats a same-cycle triggering capture
        arm = 1'b1; cap(32'h400, LDW); arm = 1'b0;
        chk("armprio_state", state, 1);
        chk("armprio_count", count, 0);
        chk("armprio_trig", triggered, 0);

        // reset in POST with 7 entries
        for (int i = 0; i < 3; i++) cap(32'h500 + 32'(4*i), ALU);
        force_trig = 1'b1; post_cnt = 4'd7;
        tick();
        force_trig = 1'b0;
        for (int i = 3; i < 7; i++) cap(32'h500 + 32'(4*i), ALU);
        chk("pre_rst_state", state, 2);
        chk("pre_rst_count", count, 7);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_count", count, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_trig", triggered, 0);

        // DONE with nothing captured falls back to IDLE
        do_arm();
        force_trig = 1'b1; post_cnt = 4'd0;
        tick();
        force_trig = 1'b0;
        chk("empty_done", state, 3);
        chk("empty_valid", rd_valid, 0);
        tick();
        chk("empty_idle", state, 0);

        // class sweep, first 9 opcodes then forced trigger
        trig_op = 6'b111110;
        do_arm();
        for (int i = 0; i < 9; i++) cap(32'h600 + 32'(4*i), {ops[i], 26'h0});
        force_trig = 1'b1; post_cnt = 4'd0;
        tick();
        force_trig = 1'b0;
        chk("sweepA_count", count, 9);
        rd_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("sweepA_class", rd_class, clss[i]);
            tick();
        end
        rd_ready = 1'b0;

        // remaining 8 opcodes; the final 111111 record is the trigger
        trig_op = 6'b111111;
        do_arm();
        for (int i = 9; i < 17; i++) cap(32'h700 + 32'(4*i), {ops[i], 26'h0});
        chk("sweepB_state", state, 3);
        chk("sweepB_count", count, 8);
        rd_ready = 1'b1;
        for (int i = 9; i < 17; i++) begin
            chk("sweepB_class", rd_class, clss[i]);
            tick();
        end
        rd_ready = 1'b0;
        chk("sweepB_idle", state, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
